// File: rtl/output_cdf_scale_pkg.sv
// Shared types and constants for the output pipeline: widths, latency, FSM states and the
// per-stage record carried through the restoring divider.
package output_pipe_pkg;

  localparam int unsigned CDF_W    = 20;
  localparam int unsigned PIX_W    = 8;
  localparam int unsigned NUM_W    = CDF_W + PIX_W;
  localparam int unsigned PIPE_LAT = 10;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

  typedef struct packed {
    logic             valid;
    logic [NUM_W-1:0] rem;
    logic [CDF_W-1:0] den;
    logic [PIX_W-1:0] q;
    logic             ovf;
  } stage_t;

endpackage

// File: rtl/output_cdf_scale_if.sv
// Frame/pixel bus between the CDF fetch stage (master) and the scaling stage (slave).
interface output_cdf_scale_if;
  import output_pipe_pkg::*;

  logic             FrameStart;
  logic [CDF_W-1:0] CdfMin;
  logic [CDF_W-1:0] CdfTotal;
  logic             StartIn;
  logic [CDF_W-1:0] DataIn;
  logic             StartOut;
  logic [PIX_W-1:0] PixelOut;
  logic             FrameDone;
  logic             DivErr;
  logic             Overrun;

  modport master (
    output FrameStart, CdfMin, CdfTotal, StartIn, DataIn,
    input  StartOut, PixelOut, FrameDone, DivErr, Overrun
  );

  modport slave (
    input  FrameStart, CdfMin, CdfTotal, StartIn, DataIn,
    output StartOut, PixelOut, FrameDone, DivErr, Overrun
  );

endinterface

// File: rtl/output_cdf_scale_div_stage.sv
// One restoring-division step: resolves quotient bit Shift by comparing the partial
// remainder against den << Shift.
module cdf_div_stage
  import output_pipe_pkg::*;
#(
  parameter int unsigned Shift = 0
) (
  input  logic   clock,
  input  logic   reset_n,
  input  logic   i_flush,
  input  stage_t i_stage,
  output stage_t o_stage
);

  logic [NUM_W-1:0] w_dsh;
  logic             w_ge;
  logic             r_valid;
  logic [NUM_W-1:0] r_rem;
  logic [CDF_W-1:0] r_den;
  logic [PIX_W-1:0] r_q;
  logic             r_ovf;

  assign w_dsh = {{PIX_W{1'b0}}, i_stage.den} << Shift;
  assign w_ge  = (i_stage.rem >= w_dsh);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_stage.valid && !i_flush;
    end
  end

  always_ff @(posedge clock) begin
    r_rem <= w_ge ? (i_stage.rem - w_dsh) : i_stage.rem;
    r_den <= i_stage.den;
    r_q   <= {i_stage.q[PIX_W-2:0], w_ge};
    r_ovf <= i_stage.ovf;
  end

  assign o_stage = '{valid: r_valid, rem: r_rem, den: r_den, q: r_q, ovf: r_ovf};

endmodule

// File: rtl/output_cdf_scale.sv
// Maps fetched CDF values to equalized pixels via a 10-cycle divider pipeline, and tracks
// frame completion. Define OUTPUT_CDF_SCALE_ROUND_EN for round-half-up instead of truncation.
module output_cdf_scale
  import output_pipe_pkg::*;
(
  input logic               clock,
  input logic               reset_n,
  output_cdf_scale_if.slave bus
);

  state_e           r_state, w_state_d;
  logic [CDF_W-1:0] r_cnt;
  logic [CDF_W-1:0] r_min, r_total;
  logic             r_in_valid;
  logic [CDF_W-1:0] r_in_data;
  logic             r_s0_valid;
  logic [NUM_W-1:0] r_s0_rem;
  logic [CDF_W-1:0] r_s0_den;
  logic             r_s0_ovf;
  logic             r_out_valid;
  logic [PIX_W-1:0] r_pixel;
  logic             r_frame_done;
  logic             r_div_err;
  logic             r_overrun;

  logic             w_accept, w_drop, w_count_en, w_last;
  logic [CDF_W-1:0] w_den, w_x;
  logic [NUM_W-1:0] w_num;
  logic [PIX_W-1:0] w_pixel;
  stage_t           w_st [PIX_W+1];
  logic             w_unused_rem;

  // A FrameStart in the same cycle as StartIn admits that sample into the new frame.
  assign w_accept = bus.StartIn && (bus.FrameStart || (r_state == StRun));
  assign w_drop   = bus.StartIn && !bus.FrameStart && (r_state == StIdle);

  // Entry stage works from the registered sample and the already-latched frame constants.
  assign w_den = r_total - r_min;
  assign w_x   = (r_in_data < r_min) ? '0 : (r_in_data - r_min);
`ifdef OUTPUT_CDF_SCALE_ROUND_EN
  assign w_num = (({{PIX_W{1'b0}}, w_x} << PIX_W) - {{PIX_W{1'b0}}, w_x})
               + NUM_W'(w_den >> 1);
`else
  assign w_num = ({{PIX_W{1'b0}}, w_x} << PIX_W) - {{PIX_W{1'b0}}, w_x};
`endif

  assign w_st[0] = '{valid: r_s0_valid, rem: r_s0_rem, den: r_s0_den, q: '0, ovf: r_s0_ovf};

  for (genvar g = 0; g < PIX_W; g++) begin : g_div
    cdf_div_stage #(
      .Shift(PIX_W - 1 - g)
    ) u_stage (
      .clock  (clock),
      .reset_n(reset_n),
      .i_flush(bus.FrameStart),
      .i_stage(w_st[g]),
      .o_stage(w_st[g+1])
    );
  end

  assign w_unused_rem = ^w_st[PIX_W].rem;

  assign w_pixel    = (w_st[PIX_W].den == '0) ? '0 :
                      (w_st[PIX_W].ovf ? '1 : w_st[PIX_W].q);
  assign w_count_en = w_st[PIX_W].valid && (r_state == StRun) && !bus.FrameStart;
  assign w_last     = w_count_en && ((r_cnt + CDF_W'(1)) == r_total);

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: if (bus.FrameStart) w_state_d = StRun;
      StRun: begin
        if (bus.FrameStart) begin
          w_state_d = StRun;
        end else if ((r_total == '0) || w_last) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_in_valid   <= 1'b0;
      r_s0_valid   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_pixel      <= '0;
      r_frame_done <= 1'b0;
      r_div_err    <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_in_valid   <= w_accept;
      r_s0_valid   <= r_in_valid && !bus.FrameStart;
      r_out_valid  <= w_st[PIX_W].valid && !bus.FrameStart;
      r_frame_done <= w_last;
      if (w_st[PIX_W].valid) r_pixel <= w_pixel;
      if (bus.FrameStart) begin
        r_cnt     <= '0;
        r_div_err <= (bus.CdfTotal == bus.CdfMin);
        r_overrun <= 1'b0;
      end else begin
        if (w_count_en) r_cnt <= r_cnt + CDF_W'(1);
        if (w_drop) r_overrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (bus.FrameStart) begin
      r_min   <= bus.CdfMin;
      r_total <= bus.CdfTotal;
    end
    r_in_data <= bus.DataIn;
    r_s0_rem  <= w_num;
    r_s0_den  <= w_den;
    r_s0_ovf  <= (r_in_data > r_total);
  end

  assign bus.StartOut  = r_out_valid;
  assign bus.PixelOut  = r_pixel;
  assign bus.FrameDone = r_frame_done;
  assign bus.DivErr    = r_div_err;
  assign bus.Overrun   = r_overrun;

endmodule

// File: tb/tb_output_cdf_scale.sv
// Directed bench for output_cdf_scale: latency, scaling, frame completion, abort, overflow,
// degenerate histogram and asynchronous reset.
module tb_output_cdf_scale;
  import output_pipe_pkg::*;

  logic clock = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

`ifdef OUTPUT_CDF_SCALE_ROUND_EN
  localparam logic [7:0] Half = 8'd128;
`else
  localparam logic [7:0] Half = 8'd127;
`endif

  output_cdf_scale_if bus ();

  output_cdf_scale dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic frame_start(input logic [CDF_W-1:0] mn, input logic [CDF_W-1:0] tot);
    bus.FrameStart = 1'b1;
    bus.CdfMin     = mn;
    bus.CdfTotal   = tot;
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    bus.FrameStart = 1'b0;
    bus.StartIn    = 1'b0;
    bus.DataIn     = '0;
    bus.CdfMin     = '0;
    bus.CdfTotal   = '0;
    #3;
    checks++; if (bus.StartOut !== 1'b0) begin errors++;
      $display("FAIL reset_startout got %b want 0", bus.StartOut); end
    checks++; if (bus.PixelOut !== 8'd0) begin errors++;
      $display("FAIL reset_pixel got %0d want 0", bus.PixelOut); end
    checks++; if (bus.FrameDone !== 1'b0) begin errors++;
      $display("FAIL reset_framedone got %b want 0", bus.FrameDone); end
    checks++; if (bus.DivErr !== 1'b0) begin errors++;
      $display("FAIL reset_diverr got %b want 0", bus.DivErr); end
    checks++; if (bus.Overrun !== 1'b0) begin errors++;
      $display("FAIL reset_overrun got %b want 0", bus.Overrun); end
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [CDF_W-1:0] din [4] = '{20'd100, 20'd1100, 20'd600, 20'd50};
    logic [7:0]       exp [4];
    exp = '{8'd0, 8'd255, Half, 8'd0};
    frame_start(20'd100, 20'd1100);
    step();
    bus.FrameStart = 1'b0;
    checks++; if (bus.DivErr !== 1'b0) begin errors++;
      $display("FAIL basic_diverr got %b want 0", bus.DivErr); end
    for (int i = 0; i < 4; i++) begin
      bus.StartIn = 1'b1;
      bus.DataIn  = din[i];
      step();
    end
    bus.StartIn = 1'b0;
    bus.DataIn  = '0;
    for (int c = 0; c < PIPE_LAT - 4; c++) begin
      step();
      checks++; if (bus.StartOut !== 1'b0) begin errors++;
        $display("FAIL basic_early got %b want 0 at wait %0d", bus.StartOut, c); end
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (bus.StartOut !== 1'b1) begin errors++;
        $display("FAIL basic_valid%0d got %b want 1", i, bus.StartOut); end
      checks++; if (bus.PixelOut !== exp[i]) begin errors++;
        $display("FAIL basic_pixel%0d got %0d want %0d", i, bus.PixelOut, exp[i]); end
    end
    step();
    checks++; if (bus.StartOut !== 1'b0) begin errors++;
      $display("FAIL basic_tail got %b want 0", bus.StartOut); end
  endtask

  task automatic test_overflow();
    // FrameStart and StartIn together: the sample joins the new frame.
    frame_start(20'd100, 20'd1100);
    bus.StartIn = 1'b1;
    bus.DataIn  = 20'd2000;
    step();
    bus.FrameStart = 1'b0;
    bus.StartIn    = 1'b0;
    for (int c = 1; c < PIPE_LAT; c++) step();
    checks++; if (bus.StartOut !== 1'b0) begin errors++;
      $display("FAIL ovf_early got %b want 0", bus.StartOut); end
    step();
    checks++; if (bus.StartOut !== 1'b1) begin errors++;
      $display("FAIL ovf_valid got %b want 1", bus.StartOut); end
    checks++; if (bus.PixelOut !== 8'd255) begin errors++;
      $display("FAIL ovf_pixel got %0d want 255", bus.PixelOut); end
  endtask

  task automatic test_diverr();
    frame_start(20'd5, 20'd5);
    step();
    bus.FrameStart = 1'b0;
    checks++; if (bus.DivErr !== 1'b1) begin errors++;
      $display("FAIL diverr_flag got %b want 1", bus.DivErr); end
    bus.StartIn = 1'b1;
    bus.DataIn  = 20'd5;
    step();
    bus.StartIn = 1'b0;
    for (int c = 1; c < PIPE_LAT; c++) step();
    checks++; if (bus.StartOut !== 1'b0) begin errors++;
      $display("FAIL diverr_early got %b want 0", bus.StartOut); end
    step();
    checks++; if (bus.StartOut !== 1'b1) begin errors++;
      $display("FAIL diverr_valid got %b want 1", bus.StartOut); end
    checks++; if (bus.PixelOut !== 8'd0) begin errors++;
      $display("FAIL diverr_pixel got %0d want 0", bus.PixelOut); end
  endtask

  task automatic test_frame_done();
    logic [7:0] exp [4] = '{8'd0, 8'd85, 8'd170, 8'd255};
    logic       exp_v;
    int         seen;
    frame_start(20'd1, 20'd4);
    step();
    bus.FrameStart = 1'b0;
    // Four inputs spaced three cycles apart; outputs PIPE_LAT edges later.
    for (int s = 0; s < 24; s++) begin
      bus.StartIn = ((s % 3) == 0) && (s < 12);
      bus.DataIn  = CDF_W'(s / 3 + 1);
      step();
      exp_v = (s >= 10) && (((s - 10) % 3) == 0) && (s <= 19);
      checks++; if (bus.StartOut !== exp_v) begin errors++;
        $display("FAIL fd_valid edge %0d got %b want %b", s, bus.StartOut, exp_v); end
      if (exp_v) begin
        checks++; if (bus.PixelOut !== exp[(s - 10) / 3]) begin errors++;
          $display("FAIL fd_pixel edge %0d got %0d want %0d", s, bus.PixelOut,
                   exp[(s - 10) / 3]); end
      end
      checks++; if (bus.FrameDone !== (s == 19)) begin errors++;
        $display("FAIL fd_done edge %0d got %b want %b", s, bus.FrameDone, (s == 19)); end
    end
    checks++; if (bus.Overrun !== 1'b0) begin errors++;
      $display("FAIL fd_overrun_pre got %b want 0", bus.Overrun); end
    bus.StartIn = 1'b1;
    bus.DataIn  = 20'd2;
    step();
    bus.StartIn = 1'b0;
    checks++; if (bus.Overrun !== 1'b1) begin errors++;
      $display("FAIL fd_overrun got %b want 1", bus.Overrun); end
    seen = 0;
    for (int c = 0; c < PIPE_LAT + 2; c++) begin
      step();
      if (bus.StartOut === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++;
      $display("FAIL fd_dropped got %0d outputs want 0", seen); end
  endtask

  task automatic test_abort();
    logic exp_v;
    for (int s = 0; s < 25; s++) begin
      bus.FrameStart = 1'b0;
      bus.StartIn    = 1'b0;
      if (s == 0) frame_start(20'd100, 20'd1100);
      if (s >= 1 && s <= 3) begin bus.StartIn = 1'b1; bus.DataIn = 20'd600; end
      if (s == 4) frame_start(20'd0, 20'd2);
      if (s == 5) begin bus.StartIn = 1'b1; bus.DataIn = 20'd1; end
      if (s == 6) begin bus.StartIn = 1'b1; bus.DataIn = 20'd2; end
      step();
      exp_v = (s == 15) || (s == 16);
      checks++; if (bus.StartOut !== exp_v) begin errors++;
        $display("FAIL abort_valid edge %0d got %b want %b", s, bus.StartOut, exp_v); end
      if (s == 15) begin
        checks++; if (bus.PixelOut !== Half) begin errors++;
          $display("FAIL abort_pixel0 got %0d want %0d", bus.PixelOut, Half); end
      end
      if (s == 16) begin
        checks++; if (bus.PixelOut !== 8'd255) begin errors++;
          $display("FAIL abort_pixel1 got %0d want 255", bus.PixelOut); end
      end
      checks++; if (bus.FrameDone !== (s == 16)) begin errors++;
        $display("FAIL abort_done edge %0d got %b want %b", s, bus.FrameDone, (s == 16)); end
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    frame_start(20'd100, 20'd1100);
    step();
    bus.FrameStart = 1'b0;
    bus.StartIn    = 1'b1;
    bus.DataIn     = 20'd1100;
    for (int c = 0; c < 12; c++) step();
    checks++; if (bus.StartOut !== 1'b1 || bus.PixelOut !== 8'd255) begin errors++;
      $display("FAIL rst_pre got %b/%0d want 1/255", bus.StartOut, bus.PixelOut); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus.StartOut !== 1'b0) begin errors++;
      $display("FAIL rst_startout got %b want 0", bus.StartOut); end
    checks++; if (bus.PixelOut !== 8'd0) begin errors++;
      $display("FAIL rst_pixel got %0d want 0", bus.PixelOut); end
    step();
    reset_n = 1'b1;
    seen = 0;
    for (int c = 0; c < PIPE_LAT + 5; c++) begin
      if (c == 3) bus.StartIn = 1'b0;
      step();
      if (bus.StartOut === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++;
      $display("FAIL rst_flush got %0d outputs want 0", seen); end
    checks++; if (bus.Overrun !== 1'b1) begin errors++;
      $display("FAIL rst_overrun got %b want 1", bus.Overrun); end
    frame_start(20'd100, 20'd1100);
    bus.StartIn = 1'b1;
    bus.DataIn  = 20'd600;
    step();
    bus.FrameStart = 1'b0;
    bus.StartIn    = 1'b0;
    for (int c = 1; c < PIPE_LAT; c++) step();
    checks++; if (bus.StartOut !== 1'b0) begin errors++;
      $display("FAIL rst_early got %b want 0", bus.StartOut); end
    step();
    checks++; if (bus.StartOut !== 1'b1 || bus.PixelOut !== Half) begin errors++;
      $display("FAIL rst_resume got %b/%0d want 1/%0d", bus.StartOut, bus.PixelOut, Half); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_diverr();
    test_frame_done();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/output_cdf_scale.md
# output_cdf_scale

Output-pipeline stage directly downstream of the CDF fetch stage. Takes each fetched 20-bit CDF value and maps it to an 8-bit equalized pixel: round((cdf − cdf_min) × 255 / (total − cdf_min)). Fully pipelined, one result per clock, no backpressure. Tracks per-frame pixel count and flags frame completion and degenerate-histogram errors.

## Interface
- CDF_W, 20, CDF value / pixel-count width
- PIX_W, 8, output pixel width (scale factor 2^PIX_W − 1)
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- FrameStart  in  1  one-cycle pulse; latches CdfMin/CdfTotal and starts a frame
- CdfMin  in  CDF_W  minimum nonzero CDF of the frame, sampled on FrameStart
- CdfTotal  in  CDF_W  total pixel count (CDF of last bin), sampled on FrameStart
- StartIn  in  1  DataIn valid (driven by the fetch stage's StartOut)
- DataIn  in  CDF_W  CDF value; don't-care (may be X) when StartIn low
- StartOut  out  1  PixelOut valid
- PixelOut  out  PIX_W  equalized pixel
- FrameDone  out  1  one-cycle pulse coincident with the frame's last StartOut
- DivErr  out  1  sticky: CdfTotal == CdfMin for the current frame
- Overrun  out  1  sticky: StartIn seen outside RUN

## Operation
- FSM: IDLE, RUN.
  - IDLE --FrameStart--> RUN. RUN --last output counted--> IDLE. RUN --FrameStart--> RUN (abort: all pipeline valids cleared same edge, constants reloaded, counter cleared, DivErr/Overrun cleared, no FrameDone for aborted frame).
  - StartIn in IDLE: input dropped, Overrun set until next FrameStart.
- Stage 0 (entry): den = total − min (CDF_W bits). x = DataIn − min, clamped to 0 if DataIn < min. num = (x << 8) − x, plus den >> 1 when rounding is enabled (CDF_W+PIX_W bits). ovf = DataIn > total.
- Stages 1..8: restoring division, one quotient bit per stage, MSB first. Each stage carries valid, partial remainder, den, and quotient bits so far.
- Output register:
  - den == 0 → 0.
  - ovf → 255.
  - otherwise quotient.
- Since num < den·256 whenever DataIn ≤ total, 8 quotient bits suffice.
- Output counter (CDF_W bits) increments on each StartOut in RUN. When the count reaches CdfTotal, FrameDone pulses with that StartOut and the FSM returns to IDLE. CdfTotal == 0 is treated as an immediately complete frame: FSM returns to IDLE next cycle, no FrameDone.
- Datapath registers may hold stale data when invalid. Only valid bits, FSM, counter, and flags need reset.

## Timing
- Latency: StartIn sampled at edge N → StartOut/PixelOut at edge N+10. Throughput 1/cycle; back-to-back inputs yield back-to-back outputs.
- FrameStart and StartIn in the same cycle: FrameStart takes effect first, and that DataIn is accepted into the new frame using the new constants.
- Reset values: StartOut 0, PixelOut 0, FrameDone 0, DivErr 0, Overrun 0, FSM IDLE, all stage valids 0, counter 0.
- Reset mid-frame: pipeline flushed immediately (asynchronous). No outputs until the next FrameStart.
- DivErr asserts the cycle after the FrameStart that latched equal min/total.

## Configuration
- OUTPUT_CDF_SCALE_ROUND_EN defined: den>>1 is added to num (round half up).
- Not defined: no add, truncating division. Latency is identical either way.

## Structure
- Shared package output_pipe_pkg:
  - CDF_W, PIX_W, PIPE_LAT = 10
  - FSM state enum
  - stage struct (valid, rem, den, q, flags)
- Sub-module cdf_div_stage: one restoring subtract/compare step, instantiated 8× via generate.

## Test plan
- CdfMin = 100, CdfTotal = 1100; DataIn 100, 1100, 600, 50 back-to-back → PixelOut 0, 255, 128 (127 without ROUND_EN), 0 on four consecutive cycles, exactly 10 cycles after each input.
- CdfMin = CdfTotal = 5, FrameStart → DivErr = 1 next cycle; DataIn 5 → PixelOut 0.
- CdfTotal = 4, CdfMin = 1; four valid inputs with gaps → FrameDone pulses with the 4th StartOut only; FSM back in IDLE; a 5th StartIn → dropped and Overrun = 1.
- 3 pixels in flight, then FrameStart (CdfMin = 0, CdfTotal = 2) → in-flight results never appear; next inputs 1, 2 → outputs 128 (127 truncating), 255; FrameDone on the second.
- DataIn = 2000 > CdfTotal = 1100 → PixelOut 255.
- reset_n low for 1 cycle mid-stream → all outputs 0 immediately; no StartOut until after the next FrameStart and +10 cycles.
